adjust_ctrl: RTL and testbench
==============================

ADJUST_CTRL -- requirements
Module: adjust_ctrl

Interface
REQ-001 Parameter DEB_CYCLES, default 500000; consecutive cycles a synchronised button level must differ from its debounced state before the debounced state changes.
REQ-002 Parameter REPEAT_DELAY, default 25000000; cycles an increment button is held before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 5000000; cycles between auto-repeat pulses.
REQ-004 Parameter TIMEOUT_TICKS, default 30; blink_tick strobes with no press before a set state returns to RUN.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 btn_mode  input  1  raw mode button, active-high, asynchronous to clk.
REQ-008 btn_sel  input  1  raw digit-select button, active-high, asynchronous.
REQ-009 btn_inc  input  1  raw increment button, active-high, asynchronous.
REQ-010 blink_tick  input  1  one-cycle strobe from the timebase, nominally 2 Hz.
REQ-011 switch  output  1  digit-group select to the adjust datapath: 0 = hours/minutes, 1 = minutes/seconds.
REQ-012 ad  output  1  one-cycle increment strobe to the adjust datapath.
REQ-013 adj  output  4  one-hot digit select to the adjust datapath; 0000 in RUN.
REQ-014 run_en  output  1  1 = timekeeping counter may advance.
REQ-015 blank  output  4  per-digit display blank mask for blinking the selected digit.

Function
REQ-016 Each button SHALL pass through a 2-flop synchroniser, then a debounce counter; the debounced level flips after DEB_CYCLES consecutive cycles of disagreement; the counter clears on any agreement cycle.
REQ-017 A 0->1 transition of a debounced level SHALL produce a one-cycle press event for that button, in the cycle after the flip.
REQ-018 FSM states RUN, SET_HM, SET_MS; a mode press SHALL step RUN->SET_HM->SET_MS->RUN.
REQ-019 RUN: switch=0, adj=0000, ad=0, run_en=1, blank=0000; sel and inc presses ignored.
REQ-020 SET_HM: switch=0, run_en=0; SET_MS: switch=1, run_en=0.
REQ-021 Entering either set state SHALL load adj=0001.
REQ-022 A sel press in a set state SHALL rotate adj left one position, 1000 wrapping to 0001; adj SHALL always be one-hot in set states.
REQ-023 An inc press in a set state SHALL assert ad for exactly one cycle, in the same cycle as the press event.
REQ-024 While debounced inc stays 1 in a set state, further ad pulses SHALL occur REPEAT_DELAY cycles after the press event, then every REPEAT_RATE cycles, until release or state change.
REQ-025 ad SHALL never be high in two consecutive cycles and never high in RUN.
REQ-026 Simultaneous events, priority: mode > sel > inc; a lower-priority press in the same cycle is discarded, and a mode press cancels any auto-repeat in progress.
REQ-027 A blink phase bit SHALL toggle on each blink_tick in set states; it SHALL clear on entering a set state and on any sel or inc press (including repeat pulses).
REQ-028 In set states blank SHALL equal adj when the phase bit is 1, else 0000.
REQ-029 A timeout counter SHALL count blink_ticks in set states, clear on any press event, and force RUN when it reaches TIMEOUT_TICKS (counter then clears).
REQ-030 Outputs SHALL be registered; all counters SHALL saturate or clear, never wrap to false events.

Reset
REQ-031 rst_n low SHALL immediately force RUN, switch=0, ad=0, adj=0000, run_en=1, blank=0000, synchroniser/debounced levels 0, all counters 0, phase 0.
REQ-032 A button held through reset release SHALL be treated as a new press after DEB_CYCLES+synchroniser latency.
REQ-033 Reset asserted mid auto-repeat or mid set state SHALL abandon it with no further ad pulse.

Verification (DEB_CYCLES=4, REPEAT_DELAY=20, REPEAT_RATE=5, TIMEOUT_TICKS=3)
REQ-034 Reset, then btn_mode glitch high 3 cycles -> no state change; held 10 cycles -> SET_HM, adj=0001, run_en=0, switch=0.
REQ-035 In SET_HM, four sel presses -> adj 0010, 0100, 1000, 0001; mode press -> SET_MS, switch=1, adj=0001; mode press -> RUN, adj=0000.
REQ-036 In SET_MS, inc held 40 cycles past press -> ad pulses at press, +20, +25, +30, +35, +40 cycles; none after release.
REQ-037 mode and sel press events in the same cycle from SET_HM -> SET_MS, adj=0001, sel discarded.
REQ-038 In SET_HM, 3 blink_ticks without presses -> RUN; blank toggles 0001/0000 on each tick beforehand.
REQ-039 rst_n pulsed low during auto-repeat -> outputs at reset values same cycle, no ad until a new press in a set state.

Source files
------------

// File: rtl/adjust_ctrl.sv
// Button-driven time-adjust controller: synchronises and debounces three buttons,
// steps RUN/SET_HM/SET_MS, selects a digit, issues increment strobes with auto-repeat.
`timescale 1ns/1ps
module adjust_ctrl #(
    parameter int unsigned DEB_CYCLES    = 500000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_RATE   = 5000000,
    parameter int unsigned TIMEOUT_TICKS = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    input  logic       blink_tick,
    output logic       switch,
    output logic       ad,
    output logic [3:0] adj,
    output logic       run_en,
    output logic [3:0] blank
);

    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);
    localparam int REP_W = $clog2(REP_MAX + 1);
    localparam int TO_W  = $clog2(TIMEOUT_TICKS + 1);

    localparam logic [DEB_W-1:0] DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_TICKS - 1);

    localparam int B_MODE = 0;
    localparam int B_SEL  = 1;
    localparam int B_INC  = 2;

    typedef enum logic [1:0] {ST_RUN, ST_SET_HM, ST_SET_MS} state_t;

    logic [2:0]       r_sync1, r_sync2, r_deb;
    logic [DEB_W-1:0] r_deb_cnt [3];
    logic [2:0]       w_rise;

    state_t           r_state, w_state_nx;
    logic             r_phase, w_phase_nx;
    logic             r_rep_on, w_rep_on_nx;
    logic             r_rep_first, w_rep_first_nx;
    logic [REP_W-1:0] r_rep_cnt, w_rep_cnt_nx;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt_nx;
    logic [3:0]       w_adj_nx;
    logic             w_ad_nx;
    logic             w_rep_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_deb   <= '0;
            for (int i = 0; i < 3; i++) r_deb_cnt[i] <= '0;
        end else begin
            r_sync1 <= {btn_inc, btn_sel, btn_mode};
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_deb[i]) begin
                    if (r_deb_cnt[i] == DEB_LAST) begin
                        r_deb[i]     <= ~r_deb[i];
                        r_deb_cnt[i] <= '0;
                    end else begin
                        r_deb_cnt[i] <= r_deb_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    r_deb_cnt[i] <= '0;
                end
            end
        end
    end

    // Press event is decoded one cycle early so the registered outputs react in the press cycle.
    always_comb begin
        for (int i = 0; i < 3; i++)
            w_rise[i] = r_sync2[i] & ~r_deb[i] & (r_deb_cnt[i] == DEB_LAST);
    end

    assign w_rep_hit = r_rep_first ? (r_rep_cnt == DELAY_LAST) : (r_rep_cnt == RATE_LAST);

    always_comb begin
        w_state_nx     = r_state;
        w_adj_nx       = adj;
        w_phase_nx     = r_phase;
        w_ad_nx        = 1'b0;
        w_rep_on_nx    = r_rep_on;
        w_rep_first_nx = r_rep_first;
        w_rep_cnt_nx   = r_rep_cnt;
        w_to_cnt_nx    = r_to_cnt;
        if (r_state == ST_RUN) begin
            w_adj_nx       = 4'b0000;
            w_phase_nx     = 1'b0;
            w_rep_on_nx    = 1'b0;
            w_rep_first_nx = 1'b0;
            w_rep_cnt_nx   = '0;
            w_to_cnt_nx    = '0;
            if (w_rise[B_MODE]) begin
                w_state_nx = ST_SET_HM;
                w_adj_nx   = 4'b0001;
            end
        end else if (w_rise[B_MODE]) begin
            w_state_nx  = (r_state == ST_SET_HM) ? ST_SET_MS : ST_RUN;
            w_adj_nx    = (r_state == ST_SET_HM) ? 4'b0001 : 4'b0000;
            w_phase_nx  = 1'b0;
            w_rep_on_nx = 1'b0;
            w_to_cnt_nx = '0;
        end else begin
            if (blink_tick) begin
                w_phase_nx  = ~r_phase;
                w_to_cnt_nx = r_to_cnt + TO_W'(1);
            end
            if (r_rep_on && r_deb[B_INC]) begin
                if (w_rep_hit) begin
                    w_ad_nx        = 1'b1;
                    w_rep_cnt_nx   = '0;
                    w_rep_first_nx = 1'b0;
                end else begin
                    w_rep_cnt_nx = r_rep_cnt + REP_W'(1);
                end
            end else begin
                w_rep_on_nx = 1'b0;
            end
            if (w_rise[B_SEL]) begin
                w_adj_nx    = {adj[2:0], adj[3]};
                w_to_cnt_nx = '0;
            end else if (w_rise[B_INC]) begin
                w_ad_nx        = 1'b1;
                w_rep_on_nx    = 1'b1;
                w_rep_first_nx = 1'b1;
                w_rep_cnt_nx   = '0;
                w_to_cnt_nx    = '0;
            end
            if (w_rise[B_SEL] || w_ad_nx) w_phase_nx = 1'b0;
            if (blink_tick && (r_to_cnt == TO_LAST) && !w_rise[B_SEL] && !w_rise[B_INC]) begin
                w_state_nx  = ST_RUN;
                w_adj_nx    = 4'b0000;
                w_phase_nx  = 1'b0;
                w_rep_on_nx = 1'b0;
                w_to_cnt_nx = '0;
                w_ad_nx     = 1'b0;
            end
            // Guarantees a gap between strobes even for degenerate repeat settings.
            if (ad) w_ad_nx = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_phase     <= 1'b0;
            r_rep_on    <= 1'b0;
            r_rep_first <= 1'b0;
            r_rep_cnt   <= '0;
            r_to_cnt    <= '0;
            switch      <= 1'b0;
            ad          <= 1'b0;
            adj         <= 4'b0000;
            run_en      <= 1'b1;
            blank       <= 4'b0000;
        end else begin
            r_state     <= w_state_nx;
            r_phase     <= w_phase_nx;
            r_rep_on    <= w_rep_on_nx;
            r_rep_first <= w_rep_first_nx;
            r_rep_cnt   <= w_rep_cnt_nx;
            r_to_cnt    <= w_to_cnt_nx;
            switch      <= (w_state_nx == ST_SET_MS);
            ad          <= w_ad_nx;
            adj         <= w_adj_nx;
            run_en      <= (w_state_nx == ST_RUN);
            blank       <= w_phase_nx ? w_adj_nx : 4'b0000;
        end
    end

endmodule

// File: tb/tb_adjust_ctrl.sv
// Scoreboard bench for adjust_ctrl: stimulus queues expected output changes with their
// cycle; the monitor pops and compares each time the output vector changes.
`timescale 1ns/1ps
module tb_adjust_ctrl;

    logic       clk;
    logic       rst_n;
    logic       btn_mode, btn_sel, btn_inc, blink_tick;
    logic       switch, ad, run_en;
    logic [3:0] adj, blank;

    adjust_ctrl #(
        .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .TIMEOUT_TICKS(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .blink_tick(blink_tick),
        .switch(switch), .ad(ad), .adj(adj), .run_en(run_en), .blank(blank)
    );

    typedef struct {
        int          cyc;
        logic [10:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Output vector order: {switch, ad, adj, run_en, blank}
    task automatic expect_at(input string name, input int c, input logic sw, input logic a,
                             input logic [3:0] aj, input logic run, input logic [3:0] bl);
        exp_t e;
        e.cyc  = c;
        e.val  = {sw, a, aj, run, bl};
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Mask bits: [0]=mode [1]=sel [2]=inc; a debounced press shows 6 cycles after the raw edge.
    task automatic press(input logic [2:0] m, input int hold);
        {btn_inc, btn_sel, btn_mode} = m;
        repeat (hold) tick();
        {btn_inc, btn_sel, btn_mode} = 3'b000;
        repeat (12) tick();
    endtask

    task automatic pulse_tick();
        blink_tick = 1'b1;
        tick();
        blink_tick = 1'b0;
    endtask

    initial begin : monitor
        logic [10:0] snap, prev;
        bit          have_prev;
        exp_t        e;
        have_prev = 0;
        prev      = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                snap = {switch, ad, adj, run_en, blank};
                if (!have_prev || snap != prev) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_change: cycle %0d got %b, required no change from %b",
                                 cyc, snap, prev);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.cyc != cyc || e.val !== snap)
                            begin
                                errors++;
                                $display("FAIL %s: got %b at cycle %0d, required %b at cycle %0d",
                                         e.name, snap, cyc, e.val, e.cyc);
                            end
                    end
                end
                prev      = snap;
                have_prev = 1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, %0d expected events outstanding", exp_q.size());
        $fatal(1, "bench time limit");
    end

    initial begin : stimulus
        int c;
        int offs [6] = '{6, 26, 31, 36, 41, 46};
        rst_n = 1'b0;
        {btn_inc, btn_sel, btn_mode} = 3'b000;
        blink_tick = 1'b0;
        repeat (3) tick();
        rst_n  = 1'b1;
        mon_en = 1'b1;
        expect_at("reset", cyc, 0, 0, 4'b0000, 1, 4'b0000);

        // Short mode glitch must not register
        press(3'b001, 3);

        expect_at("mode_run_to_hm", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000);
        press(3'b001, 10);

        expect_at("sel1", cyc + 6, 0, 0, 4'b0010, 0, 4'b0000); press(3'b010, 6);
        expect_at("sel2", cyc + 6, 0, 0, 4'b0100, 0, 4'b0000); press(3'b010, 6);
        expect_at("sel3", cyc + 6, 0, 0, 4'b1000, 0, 4'b0000); press(3'b010, 6);
        expect_at("sel4_wrap", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b010, 6);

        expect_at("mode_hm_to_ms", cyc + 6, 1, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);
        expect_at("mode_ms_to_run", cyc + 6, 0, 0, 4'b0000, 1, 4'b0000); press(3'b001, 6);

        // sel and inc ignored in RUN
        press(3'b010, 6);
        press(3'b100, 6);

        expect_at("mode_to_hm_2", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);
        expect_at("mode_to_ms_2", cyc + 6, 1, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);

        // Held increment: press strobe, then +20, then every 5
        c = cyc;
        foreach (offs[i]) begin
            expect_at($sformatf("inc_pulse_%0d", i), c + offs[i], 1, 1, 4'b0001, 0, 4'b0000);
            expect_at($sformatf("inc_gap_%0d", i), c + offs[i] + 1, 1, 0, 4'b0001, 0, 4'b0000);
        end
        press(3'b100, 42);
        repeat (10) tick();

        expect_at("mode_to_run_3", cyc + 6, 0, 0, 4'b0000, 1, 4'b0000); press(3'b001, 6);
        expect_at("mode_to_hm_3", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);
        expect_at("mode_sel_same_cycle", cyc + 6, 1, 0, 4'b0001, 0, 4'b0000); press(3'b011, 6);

        expect_at("mode_to_run_4", cyc + 6, 0, 0, 4'b0000, 1, 4'b0000); press(3'b001, 6);
        expect_at("mode_to_hm_4", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);

        // Blink and timeout
        expect_at("blink_tick1", cyc + 1, 0, 0, 4'b0001, 0, 4'b0001); pulse_tick(); repeat (4) tick();
        expect_at("blink_tick2", cyc + 1, 0, 0, 4'b0001, 0, 4'b0000); pulse_tick(); repeat (4) tick();
        expect_at("timeout_run", cyc + 1, 0, 0, 4'b0000, 1, 4'b0000); pulse_tick(); repeat (4) tick();

        // Sel press clears the blink phase and the timeout count
        expect_at("mode_to_hm_5", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);
        expect_at("blink_on", cyc + 1, 0, 0, 4'b0001, 0, 4'b0001); pulse_tick(); repeat (4) tick();
        expect_at("sel_clears_phase", cyc + 6, 0, 0, 4'b0010, 0, 4'b0000); press(3'b010, 6);
        expect_at("blink_on_sel_digit", cyc + 1, 0, 0, 4'b0010, 0, 4'b0010); pulse_tick(); repeat (4) tick();

        // Reset in the middle of auto-repeat with the button still held
        c = cyc;
        expect_at("inc_before_reset", c + 6, 0, 1, 4'b0010, 0, 4'b0000);
        expect_at("inc_before_reset_gap", c + 7, 0, 0, 4'b0010, 0, 4'b0000);
        expect_at("async_reset", c + 15, 0, 0, 4'b0000, 1, 4'b0000);
        btn_inc = 1'b1;
        repeat (15) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (40) tick();
        btn_inc = 1'b0;
        repeat (15) tick();

        expect_at("mode_after_reset", cyc + 6, 0, 0, 4'b0001, 0, 4'b0000); press(3'b001, 6);
        c = cyc;
        expect_at("inc_after_reset", c + 6, 0, 1, 4'b0001, 0, 4'b0000);
        expect_at("inc_after_reset_gap", c + 7, 0, 0, 4'b0001, 0, 4'b0000);
        press(3'b100, 6);
        repeat (20) tick();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_events: %0d outstanding, next %s required at cycle %0d, required 0 outstanding",
                     exp_q.size(), exp_q[0].name, exp_q[0].cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
